// File: rtl/harness_stim_sequencer_pkg.sv
// Shared types and helpers for the stimulus sequencer.
// State encoding, response modes and sizing functions.
package harness_stim_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } seq_state_e;

  localparam logic MODE_LOOPBACK = 1'b0;
  localparam logic MODE_INVERT   = 1'b1;

  function automatic logic [31:0] expected(
    input logic [31:0] stim,
    input logic        mode
  );
    return (mode == MODE_INVERT) ? ~stim : stim;
  endfunction

  function automatic int fail_count_w(
    input int vectors,
    input int channels
  );
    return $clog2(vectors * channels + 1);
  endfunction

endpackage

// File: rtl/harness_stim_sequencer_chan_slot.sv
// One channel of the sequencer: stimulus register, handshake
// flags, response hold register and mismatch detection.
module harness_chan_slot
  import harness_stim_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit MODE   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              abort,
  input  logic              listen,
  input  logic [DATA_W-1:0] load_data,
  input  logic              stim_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              stim_valid,
  output logic [DATA_W-1:0] stim_data,
  output logic              accepted_nx,
  output logic              received_nx,
  output logic              mismatch
);

  localparam logic [31:0] DMASK =
    32'((64'd1 << DATA_W) - 64'd1);

  logic              accepted;
  logic              received;
  logic [DATA_W-1:0] hold;
  logic              hs;
  logic              rsp;

  assign hs = stim_valid & stim_ready;
  // Responses only count once this channel's stimulus was taken.
  assign rsp = listen & accepted & ~received & resp_valid;

  assign accepted_nx = accepted | hs;
  assign received_nx = received | rsp;

  assign mismatch =
    |((32'(hold) ^ expected(32'(stim_data), MODE)) & DMASK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stim_valid <= 1'b0;
      stim_data  <= '0;
      accepted   <= 1'b0;
      received   <= 1'b0;
      hold       <= '0;
    end else if (load) begin
      stim_valid <= 1'b1;
      stim_data  <= load_data;
      accepted   <= 1'b0;
      received   <= 1'b0;
    end else begin
      if (abort) begin
        stim_valid <= 1'b0;
      end else if (hs) begin
        stim_valid <= 1'b0;
        accepted   <= 1'b1;
      end
      if (rsp) begin
        received <= 1'b1;
        hold     <= resp_data;
      end
    end
  end

endmodule

// File: rtl/harness_stim_sequencer.sv
// Vector sequencer driving CHANNELS DUT lanes in lockstep,
// checking responses and reporting pass/fail with a finish pulse.
module harness_stim_sequencer
  import harness_stim_sequencer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DATA_W      = 8,
  parameter int NUM_VECTORS = 16,
  parameter int TIMEOUT     = 64,
  parameter int MODE        = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic [CHANNELS-1:0]          stim_valid,
  input  logic [CHANNELS-1:0]          stim_ready,
  output logic [CHANNELS*DATA_W-1:0]   stim_data,
  input  logic [CHANNELS-1:0]          resp_valid,
  input  logic [CHANNELS*DATA_W-1:0]   resp_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout_err,
  output logic [fail_count_w(NUM_VECTORS, CHANNELS)-1:0]
                                       fail_count,
  output logic                         finish
);

  localparam int FCW  = fail_count_w(NUM_VECTORS, CHANNELS);
  localparam int FCW1 = FCW + 1;
  localparam int VW   =
    (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [FCW-1:0] FC_MAX = '1;

  seq_state_e state, state_n;

  logic [VW-1:0]       vec;
  logic [VW-1:0]       load_vec;
  logic [TW-1:0]       tcnt;
  logic                load;
  logic                abort;
  logic                restart;
  logic                tmo;
  logic                listen;
  logic                last_vec;
  logic                tmo_hit;
  logic [CHANNELS-1:0] acc_nx;
  logic [CHANNELS-1:0] rcv_nx;
  logic [CHANNELS-1:0] mis;
  logic [FCW:0]        nmis;
  logic [FCW:0]        fc_sum;

  assign listen   = (state == DRIVE) || (state == WAIT);
  assign last_vec = vec == VW'(NUM_VECTORS - 1);
  assign tmo_hit  = tcnt == TW'(TIMEOUT - 1);
  assign load_vec = restart ? '0 : vec + VW'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    harness_chan_slot #(
      .DATA_W (DATA_W),
      .MODE   (MODE != 0)
    ) u_slot (
      .clock       (clock),
      .reset       (reset),
      .load        (load),
      .abort       (abort),
      .listen      (listen),
      .load_data   (DATA_W'(int'(load_vec) * CHANNELS + c)),
      .stim_ready  (stim_ready[c]),
      .resp_valid  (resp_valid[c]),
      .resp_data   (resp_data[c*DATA_W +: DATA_W]),
      .stim_valid  (stim_valid[c]),
      .stim_data   (stim_data[c*DATA_W +: DATA_W]),
      .accepted_nx (acc_nx[c]),
      .received_nx (rcv_nx[c]),
      .mismatch    (mis[c])
    );
  end

  always_comb begin
    nmis = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      nmis = nmis + FCW1'(mis[c]);
    end
    fc_sum = {1'b0, fail_count} + nmis;
  end

  // A completing handshake/response takes priority over timeout.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    abort   = 1'b0;
    restart = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          restart = 1'b1;
          load    = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (&acc_nx) begin
          state_n = WAIT;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      WAIT: begin
        if (&rcv_nx) begin
          state_n = CHECK;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      CHECK: begin
        if (last_vec) begin
          state_n = DONE;
        end else begin
          load    = 1'b1;
          state_n = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      vec         <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      fail_count  <= '0;
      finish      <= 1'b0;
    end else begin
      state  <= state_n;
      finish <= (state_n == DONE) && (state != DONE);
      if (load) begin
        tcnt <= '0;
        vec  <= load_vec;
      end else if (listen) begin
        tcnt <= tcnt + TW'(1);
      end
      if (restart) begin
        timeout_err <= 1'b0;
      end else if (tmo) begin
        timeout_err <= 1'b1;
      end
      if (restart) begin
        fail_count <= '0;
      end else if (state == CHECK) begin
        fail_count <= (fc_sum > FCW1'(FC_MAX)) ?
                      FC_MAX : fc_sum[FCW-1:0];
      end
    end
  end

  assign busy = (state == DRIVE) || (state == WAIT) ||
                (state == CHECK);
  assign done = state == DONE;
  assign pass = done && (fail_count == '0) && !timeout_err;

endmodule

// File: tb/tb_harness_stim_sequencer.sv
// Randomized bench for harness_stim_sequencer with a
// behavioural DUT model and per-vector mismatch scoreboard.
module tb_harness_stim_sequencer;

  localparam int CH  = 4;
  localparam int DW  = 8;
  localparam int NV  = 16;
  localparam int TO  = 64;
  localparam int FCW = 7;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic start_req = 1'b0;
  logic start_noise = 1'b0;
  logic start;
  assign start = start_req | start_noise;

  logic [CH-1:0]    ready = '0;
  logic [CH-1:0]    rv = '0;
  logic [CH*DW-1:0] rd = '0;

  logic [CH-1:0]    sv0, sv1;
  logic [CH*DW-1:0] sd0, sd1;
  logic             busy0, done0, pass0, to0, fin0;
  logic             busy1, done1, pass1, to1, fin1;
  logic [FCW-1:0]   fc0, fc1;

  always #5 clock = ~clock;

  harness_stim_sequencer #(
    .CHANNELS(CH), .DATA_W(DW), .NUM_VECTORS(NV),
    .TIMEOUT(TO), .MODE(0)
  ) u_dut (
    .clock(clock), .reset(rst_n), .start(start),
    .stim_valid(sv0), .stim_ready(ready), .stim_data(sd0),
    .resp_valid(rv), .resp_data(rd),
    .busy(busy0), .done(done0), .pass(pass0),
    .timeout_err(to0), .fail_count(fc0), .finish(fin0)
  );

  harness_stim_sequencer #(
    .CHANNELS(CH), .DATA_W(DW), .NUM_VECTORS(NV),
    .TIMEOUT(TO), .MODE(1)
  ) u_inv (
    .clock(clock), .reset(rst_n), .start(start),
    .stim_valid(sv1), .stim_ready(ready), .stim_data(sd1),
    .resp_valid(rv), .resp_data(rd),
    .busy(busy1), .done(done1), .pass(pass1),
    .timeout_err(to1), .fail_count(fc1), .finish(fin1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DUT model configuration
  int mmode = 0;
  int max_stall = 0;
  int max_dly = 0;
  int drop_vec = -1;
  int drop_ch = -1;
  bit dup_en = 0;
  bit noise_en = 0;
  bit clr_req = 0;

  int         hs_cnt[CH];
  int         stall[CH];
  int         dly[CH];
  bit         pend[CH];
  bit         dpend[CH];
  logic [7:0] pdata[CH];
  bit         hv[CH];
  logic [7:0] hd[CH];
  int         mis0[NV];
  int         mis1[NV];

  function automatic logic [7:0] respond(input logic [7:0] s);
    case (mmode)
      1: return ~s;
      2: return ($urandom % 4 == 0) ?
                s ^ 8'($urandom_range(1, 255)) : s;
      default: return s;
    endcase
  endfunction

  initial begin
    logic [7:0] s;
    int k;
    forever begin
      @(negedge clock);
      if (clr_req) begin
        for (int c = 0; c < CH; c++) begin
          hs_cnt[c] = 0;
          pend[c] = 0;
          dpend[c] = 0;
          hv[c] = 0;
          stall[c] = $urandom_range(0, max_stall);
        end
        for (int v = 0; v < NV; v++) begin
          mis0[v] = 0;
          mis1[v] = 0;
        end
        clr_req = 0;
      end
      if (!rst_n) begin
        for (int c = 0; c < CH; c++) begin
          pend[c] = 0;
          dpend[c] = 0;
          hv[c] = 0;
        end
        rv = '0;
        ready = '0;
        start_noise = 0;
        continue;
      end
      for (int c = 0; c < CH; c++) begin
        s = sd0[c*DW +: DW];
        rv[c] = 1'b0;
        if (dpend[c]) begin
          rv[c] = 1'b1;
          rd[c*DW +: DW] = ~pdata[c];
          dpend[c] = 0;
        end else if (pend[c]) begin
          if (dly[c] == 0) begin
            rv[c] = 1'b1;
            rd[c*DW +: DW] = pdata[c];
            pend[c] = 0;
            if (dup_en && c == 0) dpend[c] = 1;
          end else begin
            dly[c]--;
          end
        end
        if (hv[c]) chk("stim_hold", 32'(s), 32'(hd[c]));
        if (sv0[c] && stall[c] > 0) begin
          ready[c] = 1'b0;
          stall[c]--;
        end else begin
          ready[c] = 1'b1;
        end
        if (sv0[c] && ready[c]) begin
          k = hs_cnt[c];
          chk("stim_data", 32'(s), 32'((k * CH + c) & 255));
          hs_cnt[c]++;
          hv[c] = 0;
          if (!(k == drop_vec && c == drop_ch)) begin
            pend[c] = 1;
            dly[c] = $urandom_range(0, max_dly);
            pdata[c] = respond(s);
            if (k < NV) begin
              mis0[k] += int'(pdata[c] != s);
              mis1[k] += int'(pdata[c] != ~s);
            end
          end
          stall[c] = $urandom_range(0, max_stall);
        end else begin
          hv[c] = sv0[c];
          hd[c] = s;
        end
        if (noise_en && !rv[c] && sv0[c] && !ready[c] &&
            ($urandom % 2 == 0)) begin
          rv[c] = 1'b1;
          rd[c*DW +: DW] = 8'($urandom);
        end
      end
      start_noise = noise_en && busy0 && ($urandom % 6 == 0);
    end
  end

  task automatic setup(input int mm, input int ms, input int md,
                       input int dv, input bit dup,
                       input bit noise);
    mmode = mm;
    max_stall = ms;
    max_dly = md;
    drop_vec = dv;
    drop_ch = (dv >= 0) ? 1 : -1;
    dup_en = dup;
    noise_en = noise;
    repeat (6) @(posedge clock);
    clr_req = 1;
    @(negedge clock);
    #1;
    @(posedge clock);
    #1 start_req = 1'b1;
    @(posedge clock);
    #1 start_req = 1'b0;
  endtask

  task automatic wait_finish(output int cyc);
    cyc = 1;
    while (!fin0 && cyc < 3000) begin
      @(posedge clock);
      #1 cyc++;
    end
    chk("finish_seen", 32'(fin0), 32'd1);
  endtask

  task automatic check_end(input string tag, input bit exp_to,
                           input int ncomp);
    int e0, e1, ehs;
    e0 = 0;
    e1 = 0;
    for (int v = 0; v < ncomp; v++) begin
      e0 += mis0[v];
      e1 += mis1[v];
    end
    ehs = exp_to ? drop_vec + 1 : NV;
    chk({tag, ":done"}, 32'(done0), 32'd1);
    chk({tag, ":fc"}, 32'(fc0), 32'(e0));
    chk({tag, ":pass"}, 32'(pass0), 32'(e0 == 0 && !exp_to));
    chk({tag, ":timeout"}, 32'(to0), 32'(exp_to));
    chk({tag, ":valid_low"}, 32'(sv0), 32'd0);
    chk({tag, ":inv_fc"}, 32'(fc1), 32'(e1));
    chk({tag, ":inv_pass"}, 32'(pass1),
        32'(e1 == 0 && !exp_to));
    chk({tag, ":inv_timeout"}, 32'(to1), 32'(exp_to));
    chk({tag, ":inv_fin"}, {fin1, done1, sv1}, {2'b11, 4'b0});
    for (int c = 0; c < CH; c++) begin
      chk({tag, ":hs_count"}, 32'(hs_cnt[c]), 32'(ehs));
    end
    @(posedge clock);
    #1;
    chk({tag, ":finish_pulse"}, 32'(fin0), 32'd0);
    chk({tag, ":done_hold"}, {done0, busy0}, 32'b10);
    noise_en = 0;
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_outputs", {sv0, busy0, done0, pass0, to0, fin0},
        32'd0);
    chk("rst_fc", {fc0, sd0}, 32'd0);
    @(negedge clock) rst_n = 1'b1;

    // always-ready loopback: exact latency
    setup(0, 0, 0, -1, 0, 0);
    wait_finish(cyc);
    chk("lat_finish_cycle", 32'(cyc), 32'(3 * NV + 1));
    check_end("loop", 0, NV);

    // random ready stalls and response delays
    setup(0, 5, 3, -1, 0, 0);
    wait_finish(cyc);
    check_end("stall", 0, NV);

    // inverting DUT
    setup(1, 2, 1, -1, 0, 0);
    wait_finish(cyc);
    check_end("invert", 0, NV);

    // random corruption
    setup(2, 3, 2, -1, 0, 0);
    wait_finish(cyc);
    check_end("corrupt", 0, NV);

    // channel 1 drops its response on vector 5
    setup(0, 0, 0, 5, 0, 0);
    wait_finish(cyc);
    chk("tmo_finish_cycle", 32'(cyc), 32'(3 * 5 + TO + 1));
    check_end("timeout", 1, 5);

    // reset during vector 7 WAIT
    setup(1, 0, 0, -1, 0, 0);
    cyc = 0;
    while (hs_cnt[0] < 8 && cyc < 200) begin
      @(posedge clock);
      #1 cyc++;
    end
    chk("rst_reach_v7", 32'(hs_cnt[0]), 32'd8);
    chk("rst_pre_fc", 32'(fc0), 32'(7 * CH));
    chk("rst_pre_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {sv0, busy0, done0, pass0, to0, fin0}, 32'd0);
    chk("rst_mid_fc", 32'(fc0), 32'd0);
    repeat (3) begin
      @(posedge clock);
      #1 chk("rst_no_finish", 32'(fin0), 32'd0);
    end
    @(negedge clock) rst_n = 1'b1;
    setup(0, 0, 0, -1, 0, 0);
    wait_finish(cyc);
    chk("post_rst_cycle", 32'(cyc), 32'(3 * NV + 1));
    check_end("post_rst", 0, NV);

    // duplicate / early responses and start while busy
    setup(0, 3, 2, -1, 1, 1);
    wait_finish(cyc);
    check_end("noise", 0, NV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
